// File: rtl/escritor_crono.sv
// rtl/escritor_crono.sv - writes the edited BCD countdown value into the RTC timer registers over the muxed AD bus.
// Optional snapshot BCD validation: define BCD_VALIDO_EN.
module escritor_crono #(
  parameter int unsigned T_FASE   = 4,
  parameter logic [7:0]  DIR_SEG  = 8'h41,
  parameter logic [7:0]  DIR_MIN  = 8'h42,
  parameter logic [7:0]  DIR_HORA = 8'h43
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       inicio,
  input  logic [7:0] dato_seg,
  input  logic [7:0] dato_min,
  input  logic [7:0] dato_hora,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_n,
  output logic       ocupado,
  output logic       listo,
  output logic       error_bcd
);

  typedef enum logic [3:0] {
    REPOSO,
    DIR_PREP,
    DIR_WR,
    DIR_HOLD,
    DATO_PREP,
    DATO_WR,
    DATO_HOLD,
    PAUSA,
    FIN
  } estado_t;

  localparam logic [3:0] C_ULT = 4'(T_FASE - 1);

  estado_t    r_estado;
  estado_t    w_estado_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [7:0] r_seg;
  logic [7:0] r_min;
  logic [7:0] r_hora;
  logic       w_carga;
  logic       w_err;
  logic       w_bcd_ok;
  logic       w_fin_fase;

  logic [7:0] r_ad_out;
  logic       r_ad_oe;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad_n;
  logic       r_ocupado;
  logic       r_listo;
  logic       r_error;

  logic [7:0] w_ad_out;
  logic       w_ad_oe;
  logic       w_cs_n;
  logic       w_wr_n;
  logic       w_ad_n;
  logic       w_ocupado;
  logic       w_listo;
  logic [7:0] w_dir;
  logic [7:0] w_dato;

`ifdef BCD_VALIDO_EN
  function automatic logic bcd_valido(input logic [7:0] v, input logic [7:0] maximo);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= maximo);
  endfunction

  assign w_bcd_ok = bcd_valido(dato_seg, 8'h59) &&
                    bcd_valido(dato_min, 8'h59) &&
                    bcd_valido(dato_hora, 8'h23);
`else
  assign w_bcd_ok = 1'b1;
`endif

  assign w_fin_fase = (r_cnt == C_ULT);

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      r_estado <= REPOSO;
      r_cnt    <= 4'd0;
      r_idx    <= 2'd0;
    end else begin
      r_estado <= w_estado_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      r_seg  <= 8'h00;
      r_min  <= 8'h00;
      r_hora <= 8'h00;
    end else if (w_carga) begin
      r_seg  <= dato_seg;
      r_min  <= dato_min;
      r_hora <= dato_hora;
    end
  end

  // Every timed state holds for T_FASE cycles; PAUSA picks the next register or finishes.
  always_comb begin
    w_estado_nxt = r_estado;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_carga      = 1'b0;
    w_err        = 1'b0;
    case (r_estado)
      REPOSO: begin
        w_cnt_nxt = 4'd0;
        w_idx_nxt = 2'd0;
        if (inicio) begin
          if (w_bcd_ok) begin
            w_carga      = 1'b1;
            w_estado_nxt = DIR_PREP;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      FIN: begin
        w_estado_nxt = REPOSO;
        w_cnt_nxt    = 4'd0;
        w_idx_nxt    = 2'd0;
      end
      default: begin
        if (!w_fin_fase) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else begin
          w_cnt_nxt = 4'd0;
          case (r_estado)
            DIR_PREP:  w_estado_nxt = DIR_WR;
            DIR_WR:    w_estado_nxt = DIR_HOLD;
            DIR_HOLD:  w_estado_nxt = DATO_PREP;
            DATO_PREP: w_estado_nxt = DATO_WR;
            DATO_WR:   w_estado_nxt = DATO_HOLD;
            DATO_HOLD: w_estado_nxt = PAUSA;
            PAUSA: begin
              if (r_idx == 2'd2) begin
                w_estado_nxt = FIN;
              end else begin
                w_estado_nxt = DIR_PREP;
                w_idx_nxt    = r_idx + 2'd1;
              end
            end
            default:   w_estado_nxt = REPOSO;
          endcase
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so the bus pins come straight off flops.
  always_comb begin
    case (w_idx_nxt)
      2'd0:    begin w_dir = DIR_SEG;  w_dato = r_seg;  end
      2'd1:    begin w_dir = DIR_MIN;  w_dato = r_min;  end
      default: begin w_dir = DIR_HORA; w_dato = r_hora; end
    endcase
  end

  always_comb begin
    w_ad_out  = 8'h00;
    w_ad_oe   = 1'b0;
    w_cs_n    = 1'b1;
    w_wr_n    = 1'b1;
    w_ad_n    = 1'b1;
    w_ocupado = 1'b0;
    w_listo   = 1'b0;
    case (w_estado_nxt)
      DIR_PREP, DIR_WR, DIR_HOLD: begin
        w_ad_out  = w_dir;
        w_ad_oe   = 1'b1;
        w_cs_n    = 1'b0;
        w_ad_n    = 1'b0;
        w_wr_n    = (w_estado_nxt != DIR_WR);
        w_ocupado = 1'b1;
      end
      DATO_PREP, DATO_WR, DATO_HOLD: begin
        w_ad_out  = w_dato;
        w_ad_oe   = 1'b1;
        w_cs_n    = 1'b0;
        w_ad_n    = 1'b1;
        w_wr_n    = (w_estado_nxt != DATO_WR);
        w_ocupado = 1'b1;
      end
      PAUSA: begin
        w_ocupado = 1'b1;
      end
      FIN: begin
        w_listo = 1'b1;
      end
      default: begin
        w_ocupado = 1'b0;
      end
    endcase
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      r_ad_out  <= 8'h00;
      r_ad_oe   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_ad_n    <= 1'b1;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_ad_out  <= w_ad_out;
      r_ad_oe   <= w_ad_oe;
      r_cs_n    <= w_cs_n;
      r_rd_n    <= 1'b1;
      r_wr_n    <= w_wr_n;
      r_ad_n    <= w_ad_n;
      r_ocupado <= w_ocupado;
      r_listo   <= w_listo;
      r_error   <= w_err;
    end
  end

  assign AD_out    = r_ad_out;
  assign AD_oe     = r_ad_oe;
  assign CS_n      = r_cs_n;
  assign RD_n      = r_rd_n;
  assign WR_n      = r_wr_n;
  assign AD_n      = r_ad_n;
  assign ocupado   = r_ocupado;
  assign listo     = r_listo;
  assign error_bcd = r_error;

endmodule

// File: tb/tb_escritor_crono.sv
// tb/tb_escritor_crono.sv - randomized self-checking bench for escritor_crono against a write-list model.
module tb_escritor_crono;

  localparam int T = 4;
  localparam logic [16:0] RST_VEC = {8'h00, 1'b0, 4'b1111, 3'b000};

  logic       reloj = 1'b0;
  logic       resetM = 1'b1;
  logic       inicio = 1'b0;
  logic [7:0] dato_seg = 8'h00;
  logic [7:0] dato_min = 8'h00;
  logic [7:0] dato_hora = 8'h00;
  logic [7:0] AD_out;
  logic       AD_oe, CS_n, RD_n, WR_n, AD_n, ocupado, listo, error_bcd;

  escritor_crono #(.T_FASE(T)) dut (
    .reloj(reloj), .resetM(resetM), .inicio(inicio),
    .dato_seg(dato_seg), .dato_min(dato_min), .dato_hora(dato_hora),
    .AD_out(AD_out), .AD_oe(AD_oe), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .AD_n(AD_n), .ocupado(ocupado), .listo(listo), .error_bcd(error_bcd)
  );

  always #5 reloj = ~reloj;

  typedef struct {
    logic       adn;
    logic [7:0] val;
    int         len;
  } wr_t;

  int n_chk = 0;
  int n_pass = 0;

  wr_t wq[$];
  int  ocu_q[$];
  wr_t cur;
  int  wr_len = 0, ocu_run = 0, listo_cnt = 0, err_cnt = 0, cs_low = 0;
  int  fall_bad = 0, hold_bad = 0, rd_bad = 0;
  int  cyc = 0, listo_cyc = 0, rise_cyc = 0;
  logic [7:0] prev_ad = 8'h00;
  logic       prev_ocu = 1'b0;

  int b_wq, b_ocu, b_listo, b_err, b_cs;

  always @(negedge reloj) begin
    cyc++;
    if (WR_n === 1'b0) begin
      if (wr_len == 0) begin
        cur.adn = AD_n;
        cur.val = AD_out;
        if (AD_out !== prev_ad) fall_bad++;
      end else if (AD_out !== cur.val || AD_n !== cur.adn) begin
        hold_bad++;
      end
      wr_len++;
    end else if (wr_len != 0) begin
      cur.len = wr_len;
      wq.push_back(cur);
      wr_len = 0;
    end
    if (ocupado === 1'b1) begin
      if (!prev_ocu) rise_cyc = cyc;
      ocu_run++;
    end else if (ocu_run != 0) begin
      ocu_q.push_back(ocu_run);
      ocu_run = 0;
    end
    if (listo === 1'b1) begin listo_cnt++; listo_cyc = cyc; end
    if (error_bcd === 1'b1) err_cnt++;
    if (CS_n === 1'b0) cs_low++;
    if (RD_n !== 1'b1) rd_bad++;
    prev_ad  = AD_out;
    prev_ocu = ocupado;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic mark();
    b_wq = wq.size(); b_ocu = ocu_q.size(); b_listo = listo_cnt;
    b_err = err_cnt; b_cs = cs_low;
  endtask

  function automatic bit bcd_ok(input logic [7:0] v, input int lim);
    int d, u;
    d = int'(v) / 16;
    u = int'(v) % 16;
    return (d <= 9) && (u <= 9) && (d * 10 + u <= lim);
  endfunction

  function automatic bit val_ok(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
`ifdef BCD_VALIDO_EN
    return bcd_ok(s, 59) && bcd_ok(m, 59) && bcd_ok(h, 23);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [16:0] outv();
    return {AD_out, AD_oe, CS_n, RD_n, WR_n, AD_n, ocupado, listo, error_bcd};
  endfunction

  task automatic start(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h, input bit ok);
    mark();
    dato_seg = s; dato_min = m; dato_hora = h;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk("busy_after_start", ocupado, ok);
    chk("err_pulse", error_bcd, !ok);
  endtask

  task automatic wait_listo();
    for (int k = 0; k < 300 && listo !== 1'b1; k++) tick();
    chk("listo_timeout", listo, 1'b1);
    chk("listo_not_busy", ocupado, 1'b0);
    tick();
    tick();
  endtask

  // Expected bus activity: three address/data write pairs in seconds, minutes, hours order.
  task automatic check_xfer(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    logic [7:0] e_val [6];
    e_val[0] = 8'h41; e_val[1] = s; e_val[2] = 8'h42;
    e_val[3] = m;     e_val[4] = 8'h43; e_val[5] = h;
    chk("n_writes", wq.size() - b_wq, 6);
    for (int i = 0; i < 6; i++) begin
      if (b_wq + i < wq.size()) begin
        chk($sformatf("wr%0d_val", i), wq[b_wq + i].val, e_val[i]);
        chk($sformatf("wr%0d_adn", i), wq[b_wq + i].adn, i % 2);
        chk($sformatf("wr%0d_len", i), wq[b_wq + i].len, T);
      end else begin
        chk($sformatf("wr%0d_missing", i), 0, 1);
      end
    end
    chk("n_busy_runs", ocu_q.size() - b_ocu, 1);
    if (b_ocu < ocu_q.size()) chk("busy_len", ocu_q[b_ocu], 21 * T);
    chk("n_listo", listo_cnt - b_listo, 1);
    chk("cs_low_cycles", cs_low - b_cs, 18 * T);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s, m, h;
    bit ok;

    repeat (3) tick();
    chk("rst_ad_out", AD_out, 8'h00);
    chk("rst_ad_oe", AD_oe, 1'b0);
    chk("rst_cs_n", CS_n, 1'b1);
    chk("rst_rd_n", RD_n, 1'b1);
    chk("rst_wr_n", WR_n, 1'b1);
    chk("rst_ad_n", AD_n, 1'b1);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_listo", listo, 1'b0);
    chk("rst_error", error_bcd, 1'b0);
    resetM = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", outv(), RST_VEC);
    end

    start(8'h03, 8'h04, 8'h02, 1'b1);
    wait_listo();
    check_xfer(8'h03, 8'h04, 8'h02);

    start(8'h17, 8'h45, 8'h09, 1'b1);
    repeat (30) tick();
    dato_seg = 8'h30;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    wait_listo();
    repeat (20) tick();
    check_xfer(8'h17, 8'h45, 8'h09);
    chk("no_second_xfer", ocupado, 1'b0);

    // Reset while the minutes data strobe is low.
    start(8'h21, 8'h38, 8'h11, 1'b1);
    for (int k = 0; k < 200 && !(wq.size() - b_wq == 3 && WR_n === 1'b0); k++) tick();
    chk("min_wr_found", (wq.size() - b_wq == 3) && (WR_n === 1'b0), 1'b1);
    chk("min_wr_data", AD_out, 8'h38);
    #2 resetM = 1'b1;
    #1;
    chk("async_cs_n", CS_n, 1'b1);
    chk("async_wr_n", WR_n, 1'b1);
    chk("async_ad_oe", AD_oe, 1'b0);
    chk("async_ocupado", ocupado, 1'b0);
    repeat (3) tick();
    resetM = 1'b0;
    repeat (5) tick();
    chk("no_listo_after_rst", listo_cnt - b_listo, 0);
    start(8'h50, 8'h59, 8'h23, 1'b1);
    wait_listo();
    check_xfer(8'h50, 8'h59, 8'h23);

    // Out-of-range minutes byte.
    ok = val_ok(8'h12, 8'h65, 8'h01);
    start(8'h12, 8'h65, 8'h01, ok);
    if (ok) begin
      wait_listo();
      check_xfer(8'h12, 8'h65, 8'h01);
    end else begin
      repeat (5) tick();
      chk("bad_err_cnt", err_cnt - b_err, 1);
      chk("bad_cs_idle", cs_low - b_cs, 0);
      chk("bad_no_busy", ocu_q.size() - b_ocu, 0);
    end

    // inicio held high: restart on the first idle cycle after FIN.
    mark();
    dato_seg = 8'h01; dato_min = 8'h02; dato_hora = 8'h03;
    inicio = 1'b1;
    for (int k = 0; k < 300 && listo_cnt == b_listo; k++) tick();
    repeat (3) tick();
    chk("restart_gap", rise_cyc - listo_cyc, 2);
    inicio = 1'b0;
    wait_listo();
    chk("held_listo_cnt", listo_cnt - b_listo, 2);
    chk("held_busy_runs", ocu_q.size() - b_ocu, 2);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = 8'($urandom); m = 8'($urandom); h = 8'($urandom);
      end else begin
        s = 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 9));
        m = 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 9));
        h = 8'($urandom_range(0, 1) * 16 + $urandom_range(0, 9));
      end
      ok = val_ok(s, m, h);
      start(s, m, h, ok);
      if (ok) begin
        wait_listo();
        check_xfer(s, m, h);
      end else begin
        repeat (3) tick();
        chk("rnd_err_cnt", err_cnt - b_err, 1);
        chk("rnd_cs_idle", cs_low - b_cs, 0);
      end
      repeat ($urandom_range(0, 4)) tick();
    end

    chk("wr_fall_ad_stable", fall_bad, 0);
    chk("wr_low_ad_stable", hold_bad, 0);
    chk("rd_n_high", rd_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
